// File: rtl/lpram_port.sv
// lpram_port: single-word request/response front end for LPDDR controller port 0.
// Each accepted request becomes one 32-bit write (data push, then command) or
// one 32-bit read (command, then read FIFO pop). Requests are held off until
// calibration completes; controller FIFO faults are kept in a sticky err flag.
// Optional build macro: LPRAM_TIMEOUT_EN adds a read-wait watchdog that aborts
// a read after TIMEOUT_CYCLES and returns RD_PATTERN.
module lpram_port
`ifdef LPRAM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] RD_PATTERN     = 32'hDEADBEEF
)
`endif
(
    input  logic        clk,
    input  logic        c3_sys_rst_n,
    input  logic        calib_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    input  logic        wr_underrun,
    input  logic        wr_error,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    input  logic        rd_overflow,
    input  logic        rd_error
);

    typedef enum logic [2:0] {
        CAL_WAIT,
        IDLE,
        WR_DATA,
        WR_CMD,
        WR_RSP,
        RD_CMD,
        RD_WAIT,
        RD_RSP
    } state_t;

    state_t       state;
    logic [29:2]  addr_q;
    logic [3:0]   be_q;
    logic [31:0]  wdata_q;
    logic         fifo_fault;

    // Byte-offset bits of the request address are dropped by design.
    logic         unused_addr_lsb;

`ifdef LPRAM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]  to_cnt;
`endif

    assign fifo_fault      = wr_underrun | wr_error | rd_overflow | rd_error;
    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    // Request sequencer: single-operation FSM with all outputs registered.
    always_ff @(posedge clk or negedge c3_sys_rst_n) begin
        if (!c3_sys_rst_n) begin
            state         <= CAL_WAIT;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_we        <= 1'b0;
            rsp_rdata     <= '0;
            err           <= 1'b0;
            cmd_en        <= 1'b0;
            cmd_instr     <= '0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            wr_en         <= 1'b0;
            wr_mask       <= '0;
            wr_data       <= '0;
            rd_en         <= 1'b0;
`ifdef LPRAM_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            wr_en     <= 1'b0;
            cmd_en    <= 1'b0;
            rd_en     <= 1'b0;
            rsp_valid <= 1'b0;
            if (fifo_fault) begin
                err <= 1'b1;
            end

            case (state)
                CAL_WAIT: begin
                    if (calib_done) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                // A handshake already visible to the requester wins over a
                // same-cycle calib_done drop; the drop is seen on return to IDLE.
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr[29:2];
                        be_q      <= req_be;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= req_we ? WR_DATA : RD_CMD;
                    end else if (!calib_done) begin
                        req_ready <= 1'b0;
                        state     <= CAL_WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                WR_DATA: begin
                    if (!wr_full) begin
                        wr_en   <= 1'b1;
                        wr_data <= wdata_q;
                        wr_mask <= ~be_q;
                        state   <= WR_CMD;
                    end
                end

                WR_CMD: begin
                    if (!cmd_full) begin
                        cmd_en        <= 1'b1;
                        cmd_instr     <= 3'b000;
                        cmd_bl        <= '0;
                        cmd_byte_addr <= {addr_q, 2'b00};
                        state         <= WR_RSP;
                    end
                end

                WR_RSP: begin
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b1;
                    req_ready <= calib_done;
                    state     <= IDLE;
                end

                RD_CMD: begin
                    if (!cmd_full) begin
                        cmd_en        <= 1'b1;
                        cmd_instr     <= 3'b001;
                        cmd_bl        <= '0;
                        cmd_byte_addr <= {addr_q, 2'b00};
                        state         <= RD_WAIT;
`ifdef LPRAM_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end

                RD_WAIT: begin
                    if (!rd_empty) begin
                        rd_en     <= 1'b1;
                        rsp_rdata <= rd_data;
                        state     <= RD_RSP;
                    end
`ifdef LPRAM_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                        rsp_rdata <= RD_PATTERN;
                        err       <= 1'b1;
                        req_ready <= calib_done;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end

                RD_RSP: begin
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b0;
                    req_ready <= calib_done;
                    state     <= IDLE;
                end

                default: begin
                    req_ready <= 1'b0;
                    state     <= CAL_WAIT;
                end
            endcase
        end
    end

endmodule
